// File: rtl/dec_align_correct.sv
// Receive-side PCS front end: 64-bit bit-slip aligner with block-sync slip control,
// block-source selection, and FEC transcoded-block error correction with carry.
module dec_align_correct #(
  parameter int SLIP_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] PMA_DIN,
  input  logic        CSR_DEC_INV,
  input  logic        ENDIAN_SWAP,
  input  logic        CSR_PCS_FORCE_NO_FEC,
  input  logic        FEC_SLIP,
  input  logic        FEC_LOCK,
  input  logic [65:0] GB_BLK,
  input  logic        GB_BLK_ENA,
  input  logic [65:0] DEC_OUT_FEC_BLK,
  input  logic        DEC_OUT_FEC_BLK_ENA,
  input  logic [64:0] T_BLK,
  input  logic        T_BLK_ENA,
  input  logic        CORR_VAL,
  input  logic [64:0] CORR_VECTOR,
  input  logic [9:0]  CARRY_VECTOR,
  output logic [63:0] SLIP_DOUT,
  output logic        SLIP_DOUT_VAL,
  output logic [12:0] CSR_STAT_SLIP_COUNT,
  output logic        DEC_BITSLIP,
  output logic [63:0] BS_BLK,
  output logic [1:0]  BS_SH,
  output logic        BS_ENA,
  output logic        CSR_STAT_BLOCK_LOCK,
  output logic        CSR_EXPT_LOSS_BLOCKLOCK,
  output logic [64:0] C_BLK,
  output logic        C_BLK_ENA,
  output logic        CSR_STAT_FEC_LOCK
);

  localparam int WW = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);

  logic [63:0]  w_inv;
  logic [63:0]  w_rev;
  logic [63:0]  w_word;
  logic [127:0] w_cat;
  logic         w_slip;
  logic         w_hdr_ok;
  logic         w_corr_en;
  logic [64:0]  w_corr;
  logic [9:0]   w_carry_in;
  logic [65:0]  w_src_blk;
  logic         w_src_ena;

  logic [63:0]   r_cur;
  logic [63:0]   r_prev;
  logic [5:0]    r_off;
  logic [1:0]    r_fill;
  logic          r_blk_slip;
  logic [6:0]    r_hdr_cnt;
  logic [4:0]    r_bad_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [9:0]    r_carry;

  assign w_inv = CSR_DEC_INV ? ~PMA_DIN : PMA_DIN;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_rev
      assign w_rev[gi] = w_inv[63-gi];
    end
  endgenerate

  assign w_word   = ENDIAN_SWAP ? w_rev : w_inv;
  assign w_cat    = {r_cur, r_prev} >> r_off;
  assign w_slip   = CSR_PCS_FORCE_NO_FEC ? r_blk_slip : FEC_SLIP;
  assign w_hdr_ok = GB_BLK[65] ^ GB_BLK[64];

  // Aligner: the output word for offset n starts n bits into the older word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cur               <= '0;
      r_prev              <= '0;
      r_off               <= '0;
      r_fill              <= '0;
      SLIP_DOUT           <= '0;
      SLIP_DOUT_VAL       <= 1'b0;
      DEC_BITSLIP         <= 1'b0;
      CSR_STAT_SLIP_COUNT <= '0;
    end else begin
      r_cur         <= w_word;
      r_prev        <= r_cur;
      SLIP_DOUT     <= w_cat[63:0];
      SLIP_DOUT_VAL <= (r_fill == 2'd2) && !w_slip;
      DEC_BITSLIP   <= w_slip;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if (w_slip) begin
        r_off               <= r_off + 6'd1;
        CSR_STAT_SLIP_COUNT <= CSR_STAT_SLIP_COUNT + 13'd1;
      end
    end
  end

  // Block sync: unlocked counts a valid-header streak, locked counts invalids per 64-block window.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_blk_slip              <= 1'b0;
      r_hdr_cnt               <= '0;
      r_bad_cnt               <= '0;
      r_wait_cnt              <= '0;
      CSR_STAT_BLOCK_LOCK     <= 1'b0;
      CSR_EXPT_LOSS_BLOCKLOCK <= 1'b0;
    end else begin
      r_blk_slip              <= 1'b0;
      CSR_EXPT_LOSS_BLOCKLOCK <= 1'b0;
      if (w_slip) begin
        r_hdr_cnt  <= '0;
        r_bad_cnt  <= '0;
        r_wait_cnt <= WW'(SLIP_WAIT);
      end else if (GB_BLK_ENA) begin
        if (r_wait_cnt != '0) begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
        end else if (!CSR_STAT_BLOCK_LOCK) begin
          if (!w_hdr_ok) begin
            r_hdr_cnt  <= '0;
            r_bad_cnt  <= '0;
            r_blk_slip <= 1'b1;
          end else if (r_hdr_cnt == 7'd63) begin
            r_hdr_cnt           <= '0;
            r_bad_cnt           <= '0;
            CSR_STAT_BLOCK_LOCK <= 1'b1;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 7'd1;
          end
        end else if (!w_hdr_ok && r_bad_cnt == 5'd15) begin
          r_hdr_cnt               <= '0;
          r_bad_cnt               <= '0;
          r_blk_slip              <= 1'b1;
          CSR_STAT_BLOCK_LOCK     <= 1'b0;
          CSR_EXPT_LOSS_BLOCKLOCK <= 1'b1;
        end else if (r_hdr_cnt == 7'd63) begin
          r_hdr_cnt <= '0;
          r_bad_cnt <= '0;
        end else begin
          r_hdr_cnt <= r_hdr_cnt + 7'd1;
          r_bad_cnt <= r_bad_cnt + {4'd0, !w_hdr_ok};
        end
      end
    end
  end

  assign w_src_blk = (CSR_PCS_FORCE_NO_FEC || !FEC_LOCK) ? GB_BLK : DEC_OUT_FEC_BLK;
  assign w_src_ena = (CSR_PCS_FORCE_NO_FEC || !FEC_LOCK) ? GB_BLK_ENA : DEC_OUT_FEC_BLK_ENA;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BS_BLK <= '0;
      BS_SH  <= '0;
      BS_ENA <= 1'b0;
    end else begin
      BS_BLK <= w_src_blk[63:0];
      BS_SH  <= w_src_blk[65:64];
      BS_ENA <= w_src_ena;
    end
  end

  // Without FEC lock the corrector is a transparent register and holds no carry.
  assign w_corr_en  = CORR_VAL && FEC_LOCK;
  assign w_corr     = w_corr_en ? CORR_VECTOR : '0;
  assign w_carry_in = FEC_LOCK ? r_carry : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_carry           <= '0;
      C_BLK             <= '0;
      C_BLK_ENA         <= 1'b0;
      CSR_STAT_FEC_LOCK <= 1'b0;
    end else begin
      C_BLK_ENA         <= T_BLK_ENA;
      CSR_STAT_FEC_LOCK <= FEC_LOCK;
      if (T_BLK_ENA) begin
        C_BLK   <= T_BLK ^ w_corr ^ {55'd0, w_carry_in};
        r_carry <= w_corr_en ? CARRY_VECTOR : '0;
      end else if (!FEC_LOCK) begin
        r_carry <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dec_align_correct.sv
// Randomized bench for dec_align_correct against a stream-level reference model,
// plus directed scenarios for alignment, slips, block lock loss and correction.
module tb_dec_align_correct;

  localparam int SLIP_WAIT = 4;
  localparam logic [63:0] K_WORD = 64'h0123456789ABCDEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [63:0] PMA_DIN = '0;
  logic        CSR_DEC_INV = 1'b0, ENDIAN_SWAP = 1'b0, CSR_PCS_FORCE_NO_FEC = 1'b0;
  logic        FEC_SLIP = 1'b0, FEC_LOCK = 1'b0;
  logic [65:0] GB_BLK = '0, DEC_OUT_FEC_BLK = '0;
  logic        GB_BLK_ENA = 1'b0, DEC_OUT_FEC_BLK_ENA = 1'b0;
  logic [64:0] T_BLK = '0, CORR_VECTOR = '0;
  logic        T_BLK_ENA = 1'b0, CORR_VAL = 1'b0;
  logic [9:0]  CARRY_VECTOR = '0;
  logic [63:0] SLIP_DOUT;
  logic        SLIP_DOUT_VAL, DEC_BITSLIP;
  logic [12:0] CSR_STAT_SLIP_COUNT;
  logic [63:0] BS_BLK;
  logic [1:0]  BS_SH;
  logic        BS_ENA, CSR_STAT_BLOCK_LOCK, CSR_EXPT_LOSS_BLOCKLOCK;
  logic [64:0] C_BLK;
  logic        C_BLK_ENA, CSR_STAT_FEC_LOCK;

  dec_align_correct #(.SLIP_WAIT(SLIP_WAIT)) dut (
    .CLK(CLK), .RST(RST), .PMA_DIN(PMA_DIN), .CSR_DEC_INV(CSR_DEC_INV),
    .ENDIAN_SWAP(ENDIAN_SWAP), .CSR_PCS_FORCE_NO_FEC(CSR_PCS_FORCE_NO_FEC),
    .FEC_SLIP(FEC_SLIP), .FEC_LOCK(FEC_LOCK), .GB_BLK(GB_BLK), .GB_BLK_ENA(GB_BLK_ENA),
    .DEC_OUT_FEC_BLK(DEC_OUT_FEC_BLK), .DEC_OUT_FEC_BLK_ENA(DEC_OUT_FEC_BLK_ENA),
    .T_BLK(T_BLK), .T_BLK_ENA(T_BLK_ENA), .CORR_VAL(CORR_VAL), .CORR_VECTOR(CORR_VECTOR),
    .CARRY_VECTOR(CARRY_VECTOR), .SLIP_DOUT(SLIP_DOUT), .SLIP_DOUT_VAL(SLIP_DOUT_VAL),
    .CSR_STAT_SLIP_COUNT(CSR_STAT_SLIP_COUNT), .DEC_BITSLIP(DEC_BITSLIP),
    .BS_BLK(BS_BLK), .BS_SH(BS_SH), .BS_ENA(BS_ENA),
    .CSR_STAT_BLOCK_LOCK(CSR_STAT_BLOCK_LOCK),
    .CSR_EXPT_LOSS_BLOCKLOCK(CSR_EXPT_LOSS_BLOCKLOCK),
    .C_BLK(C_BLK), .C_BLK_ENA(C_BLK_ENA), .CSR_STAT_FEC_LOCK(CSR_STAT_FEC_LOCK)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: word history, slip offset, header-sync bookkeeping, carry.
  logic [63:0] m_w1, m_w2;
  int          m_loaded, m_off, m_cnt, m_good, m_win, m_bad, m_ign;
  bit          m_lock, m_blk_slip;
  logic [9:0]  m_carry;
  logic [63:0] e_dout, e_bs_blk;
  logic [1:0]  e_bs_sh;
  logic [64:0] e_c_blk;
  bit          e_val, e_bitslip, e_loss, e_bs_ena, e_c_ena, e_fec_lock;

  function automatic logic [63:0] pma_map(input logic [63:0] d, input bit inv, input bit swap);
    logic [63:0] v, r;
    v = inv ? ~d : d;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return swap ? r : v;
  endfunction

  task automatic model_reset();
    m_w1 = '0; m_w2 = '0; m_loaded = 0; m_off = 0; m_cnt = 0;
    m_good = 0; m_win = 0; m_bad = 0; m_ign = 0; m_lock = 0; m_blk_slip = 0; m_carry = '0;
    e_dout = '0; e_val = 0; e_bitslip = 0; e_loss = 0; e_bs_blk = '0; e_bs_sh = '0;
    e_bs_ena = 0; e_c_blk = '0; e_c_ena = 0; e_fec_lock = 0;
  endtask

  task automatic model_edge();
    logic [127:0] pair;
    bit slip, valid, nxt_slip, ce;
    slip  = CSR_PCS_FORCE_NO_FEC ? m_blk_slip : FEC_SLIP;
    pair  = {m_w1, m_w2} >> m_off;
    e_dout = pair[63:0];
    e_val = (m_loaded >= 2) && !slip;
    e_bitslip = slip;
    if (slip) begin
      m_off = (m_off + 1) % 64;
      m_cnt = (m_cnt + 1) % 8192;
    end
    m_w2 = m_w1;
    m_w1 = pma_map(PMA_DIN, CSR_DEC_INV, ENDIAN_SWAP);
    if (m_loaded < 2) m_loaded++;
    nxt_slip = 0;
    e_loss = 0;
    valid = (GB_BLK[65:64] == 2'b01) || (GB_BLK[65:64] == 2'b10);
    if (slip) begin
      m_good = 0; m_win = 0; m_bad = 0; m_ign = SLIP_WAIT;
    end else if (GB_BLK_ENA) begin
      if (m_ign > 0) m_ign--;
      else if (!m_lock) begin
        if (valid) begin
          m_good++;
          if (m_good == 64) begin m_lock = 1; m_good = 0; m_win = 0; m_bad = 0; end
        end else begin
          m_good = 0; nxt_slip = 1;
        end
      end else begin
        m_win++;
        if (!valid) m_bad++;
        if (m_bad == 16) begin
          m_lock = 0; nxt_slip = 1; e_loss = 1; m_win = 0; m_bad = 0; m_good = 0;
        end else if (m_win == 64) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
    m_blk_slip = nxt_slip;
    if (CSR_PCS_FORCE_NO_FEC || !FEC_LOCK) begin
      e_bs_blk = GB_BLK[63:0]; e_bs_sh = GB_BLK[65:64]; e_bs_ena = GB_BLK_ENA;
    end else begin
      e_bs_blk = DEC_OUT_FEC_BLK[63:0]; e_bs_sh = DEC_OUT_FEC_BLK[65:64];
      e_bs_ena = DEC_OUT_FEC_BLK_ENA;
    end
    ce = CORR_VAL && FEC_LOCK;
    if (T_BLK_ENA) begin
      e_c_blk = T_BLK ^ (ce ? CORR_VECTOR : 65'd0) ^ {55'd0, (FEC_LOCK ? m_carry : 10'd0)};
      m_carry = ce ? CARRY_VECTOR : 10'd0;
    end
    if (!FEC_LOCK) m_carry = '0;
    e_c_ena = T_BLK_ENA;
    e_fec_lock = FEC_LOCK;
  endtask

  task automatic compare_all();
    chk("val", SLIP_DOUT_VAL, e_val);
    if (e_val) chk("dout", SLIP_DOUT, e_dout);
    chk("bitslip", DEC_BITSLIP, e_bitslip);
    chk("slipcnt", CSR_STAT_SLIP_COUNT, 13'(m_cnt));
    chk("lock", CSR_STAT_BLOCK_LOCK, m_lock);
    chk("loss", CSR_EXPT_LOSS_BLOCKLOCK, e_loss);
    chk("bs_blk", BS_BLK, e_bs_blk);
    chk("bs_sh", BS_SH, e_bs_sh);
    chk("bs_ena", BS_ENA, e_bs_ena);
    chk("c_blk", C_BLK, e_c_blk);
    chk("c_ena", C_BLK_ENA, e_c_ena);
    chk("fec_lock", CSR_STAT_FEC_LOCK, e_fec_lock);
  endtask

  // Inputs are stable from the previous falling edge; outputs sampled on the next one.
  task automatic step();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", SLIP_DOUT, 64'd0);
    compare_all();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic idle_inputs();
    PMA_DIN = '0; CSR_DEC_INV = 0; ENDIAN_SWAP = 0; CSR_PCS_FORCE_NO_FEC = 0;
    FEC_SLIP = 0; FEC_LOCK = 0; GB_BLK = '0; GB_BLK_ENA = 0; DEC_OUT_FEC_BLK = '0;
    DEC_OUT_FEC_BLK_ENA = 0; T_BLK = '0; T_BLK_ENA = 0; CORR_VAL = 0;
    CORR_VECTOR = '0; CARRY_VECTOR = '0;
  endtask

  int n_loss, n_slip;

  initial begin
    idle_inputs();
    @(negedge CLK);
    do_reset();

    // Constant word, no inversion or swap: output equals input once two words are in.
    PMA_DIN = K_WORD;
    for (int i = 0; i < 6; i++) step();
    chk("const_word", SLIP_DOUT, K_WORD);
    chk("const_val", SLIP_DOUT_VAL, 1'b1);

    // FEC-path slips on random data: three pulses, then a full 64-slip wrap.
    n_slip = 0;
    for (int k = 0; k < 64; k++) begin
      FEC_SLIP = 1'b1;
      PMA_DIN = {$urandom, $urandom};
      step();
      n_slip += int'(DEC_BITSLIP);
      FEC_SLIP = 1'b0;
      PMA_DIN = {$urandom, $urandom};
      step();
      if (k == 2) begin
        chk("three_pulses", n_slip, 3);
        chk("count3", CSR_STAT_SLIP_COUNT, 13'd3);
      end
    end
    PMA_DIN = K_WORD;
    for (int i = 0; i < 4; i++) step();
    chk("wrap_off0", SLIP_DOUT, K_WORD);
    chk("count64", CSR_STAT_SLIP_COUNT, 13'd64);

    // Block sync: lock after 64 good headers, lose it on the 16th bad in a window.
    do_reset();
    CSR_PCS_FORCE_NO_FEC = 1'b1;
    GB_BLK_ENA = 1'b1;
    for (int i = 0; i < 64; i++) begin
      GB_BLK = {2'b01, $urandom, $urandom};
      step();
    end
    chk("got_lock", CSR_STAT_BLOCK_LOCK, 1'b1);
    n_loss = 0;
    n_slip = 0;
    for (int i = 0; i < 20; i++) begin
      GB_BLK_ENA = (i < 16);
      GB_BLK = {2'b00, $urandom, $urandom};
      step();
      n_loss += int'(CSR_EXPT_LOSS_BLOCKLOCK);
      n_slip += int'(DEC_BITSLIP);
    end
    chk("lost_lock", CSR_STAT_BLOCK_LOCK, 1'b0);
    chk("one_loss", n_loss, 1);
    chk("one_slip", n_slip, 1);

    // Correction with carry into the following block, then with FEC lock absent.
    do_reset();
    FEC_LOCK = 1'b1; T_BLK = '0; T_BLK_ENA = 1'b1;
    CORR_VAL = 1'b1; CORR_VECTOR = 65'd1; CARRY_VECTOR = 10'h3;
    step();
    chk("corr_blk0", C_BLK, 65'd1);
    CORR_VAL = 1'b0;
    step();
    chk("carry_blk1", C_BLK, 65'd3);
    FEC_LOCK = 1'b0; CORR_VAL = 1'b1;
    step();
    chk("nolock_blk0", C_BLK, 65'd0);
    step();
    chk("nolock_blk1", C_BLK, 65'd0);
    T_BLK_ENA = 1'b0;
    step();

    // Randomized traffic with occasional mid-stream asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        CSR_PCS_FORCE_NO_FEC = $urandom_range(0, 1);
        CSR_DEC_INV = $urandom_range(0, 1);
        ENDIAN_SWAP = $urandom_range(0, 1);
      end
      if (i % 97 == 0) FEC_LOCK = $urandom_range(0, 3) != 0;
      if (i == 1500) do_reset();
      PMA_DIN = {$urandom, $urandom};
      FEC_SLIP = ($urandom_range(0, 49) == 0);
      GB_BLK_ENA = $urandom_range(0, 1);
      GB_BLK = {($urandom_range(0, 19) == 0) ? 2'(2 * $urandom_range(0, 1) + 1) - 2'd1
                                            : 2'(1 + $urandom_range(0, 1)), $urandom, $urandom};
      DEC_OUT_FEC_BLK = {2'($urandom), $urandom, $urandom};
      DEC_OUT_FEC_BLK_ENA = $urandom_range(0, 1);
      T_BLK = {1'($urandom), $urandom, $urandom};
      T_BLK_ENA = $urandom_range(0, 1);
      CORR_VAL = $urandom_range(0, 1);
      CORR_VECTOR = {1'($urandom), $urandom, $urandom};
      CARRY_VECTOR = 10'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
